// File: rtl/rom_arbiter_2x.sv
// rom_arbiter_2x: round-robin arbiter that shares one asynchronous-read ROM
// between two requesters. Each transaction follows the sequence
// IDLE -> ISSUE (WAIT_CYCLES+1 cycles) -> RESP (one-cycle ack) -> IDLE.
// All outputs are registered. Reset is synchronous and active-high.
module rom_arbiter_2x #(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [2:0] addr0,
    input  logic       req1,
    input  logic [2:0] addr1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       rom_cs,
    output logic       rom_read_en,
    output logic [2:0] rom_addr,
    input  logic [7:0] rom_data
);

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [AW-1:0] addr_q;
    logic          grant_id;
    logic          last_grant;

    logic          grant_sel_c;
    logic [AW-1:0] grant_addr_c;

    // Round-robin pick: a lone requester wins; on a tie the one not granted last wins
    assign grant_sel_c  = (req0 && req1) ? ~last_grant : req1;
    assign grant_addr_c = grant_sel_c ? addr1 : addr0;

    // Transaction FSM with registered ROM strobes, ack pulses and captured data
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            addr_q      <= '0;
            grant_id    <= 1'b0;
            last_grant  <= 1'b1;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            busy        <= 1'b0;
            data_out    <= DW'(0);
            rom_cs      <= 1'b0;
            rom_read_en <= 1'b0;
            rom_addr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    if (req0 || req1) begin
                        state       <= ISSUE;
                        addr_q      <= grant_addr_c;
                        grant_id    <= grant_sel_c;
                        last_grant  <= grant_sel_c;
                        wait_cnt    <= CW'(WAIT_CYCLES);
                        busy        <= 1'b1;
                        rom_cs      <= 1'b1;
                        rom_read_en <= 1'b1;
                        rom_addr    <= grant_addr_c;
                    end
                end

                ISSUE: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - CW'(1);
                        rom_addr <= addr_q;
                    end else begin
                        // Capture edge: the only point rom_data is sampled
                        data_out    <= rom_data;
                        state       <= RESP;
                        rom_cs      <= 1'b0;
                        rom_read_en <= 1'b0;
                        rom_addr    <= '0;
                        ack0        <= ~grant_id;
                        ack1        <= grant_id;
                    end
                end

                RESP: begin
                    state <= IDLE;
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state       <= IDLE;
                    ack0        <= 1'b0;
                    ack1        <= 1'b0;
                    busy        <= 1'b0;
                    rom_cs      <= 1'b0;
                    rom_read_en <= 1'b0;
                    rom_addr    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_arbiter_2x.sv
// Bench for rom_arbiter_2x: two instances (WAIT_CYCLES 0 and 3), each driven by
// its own pair of requesters and checked every cycle against a
// transaction-timeline model, plus directed literal scenarios.
module tb_rom_arbiter_2x;

    localparam int unsigned W0 = 0;
    localparam int unsigned W1 = 3;
    localparam int RAND_STEPS = 3000;

    typedef struct {
        int         cyc;
        int         r;
        logic [7:0] data;
    } ack_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_i [2];
    logic       req1_i [2];
    logic [2:0] addr0_i [2];
    logic [2:0] addr1_i [2];
    logic       ack0_o [2];
    logic       ack1_o [2];
    logic       busy_o [2];
    logic       rom_cs_o [2];
    logic       rom_re_o [2];
    logic [2:0] rom_addr_o [2];
    logic [7:0] data_o [2];
    wire  [7:0] rom_data_w0;
    wire  [7:0] rom_data_w1;

    logic [7:0] rom [8] = '{8'h21, 8'hAB, 8'h33, 8'h99, 8'hA3, 8'hFF, 8'hCD, 8'h88};

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit hold   = 1'b0;

    // Model: each transaction is a time window starting at its grant edge k
    int         m_k    [2];
    int         m_free [2];
    bit         m_act  [2];
    bit         m_g    [2];
    bit         m_lg   [2];
    logic [2:0] m_a    [2];
    logic [7:0] m_data [2];

    ack_t alog0[$];
    ack_t alog1[$];

    always #5 clk = ~clk;

    // ROM model: combinational read, high-Z when not selected
    assign rom_data_w0 = rom_cs_o[0] ? rom[rom_addr_o[0]] : 8'hzz;
    assign rom_data_w1 = rom_cs_o[1] ? rom[rom_addr_o[1]] : 8'hzz;

    rom_arbiter_2x #(.WAIT_CYCLES(W0)) dut0 (
        .clk(clk), .rst(rst),
        .req0(req0_i[0]), .addr0(addr0_i[0]),
        .req1(req1_i[0]), .addr1(addr1_i[0]),
        .ack0(ack0_o[0]), .ack1(ack1_o[0]),
        .data_out(data_o[0]), .busy(busy_o[0]),
        .rom_cs(rom_cs_o[0]), .rom_read_en(rom_re_o[0]),
        .rom_addr(rom_addr_o[0]), .rom_data(rom_data_w0)
    );

    rom_arbiter_2x #(.WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .rst(rst),
        .req0(req0_i[1]), .addr0(addr0_i[1]),
        .req1(req1_i[1]), .addr1(addr1_i[1]),
        .ack0(ack0_o[1]), .ack1(ack1_o[1]),
        .data_out(data_o[1]), .busy(busy_o[1]),
        .rom_cs(rom_cs_o[1]), .rom_read_en(rom_re_o[1]),
        .rom_addr(rom_addr_o[1]), .rom_data(rom_data_w1)
    );

    function automatic int wd(int d);
        return (d == 0) ? int'(W0) : int'(W1);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Update the model from the inputs as they stand at edge number cyc
    task automatic model_edge(int d);
        int e;
        int w;
        bit g;
        e = cyc;
        w = wd(d);
        if (rst) begin
            m_act[d]  = 1'b0;
            m_data[d] = 8'h00;
            m_lg[d]   = 1'b1;
            m_free[d] = e + 1;
        end else begin
            if (e >= m_free[d] && (req0_i[d] || req1_i[d])) begin
                g         = (req0_i[d] && req1_i[d]) ? !m_lg[d] : req1_i[d];
                m_lg[d]   = g;
                m_g[d]    = g;
                m_a[d]    = g ? addr1_i[d] : addr0_i[d];
                m_k[d]    = e;
                m_act[d]  = 1'b1;
                m_free[d] = e + w + 3;
            end
            if (m_act[d] && e == m_k[d] + w + 1)
                m_data[d] = rom[m_a[d]];
        end
    endtask

    task automatic compare_cycle(int d);
        int w;
        bit in_issue;
        bit in_resp;
        w        = wd(d);
        in_issue = m_act[d] && cyc >= m_k[d] && cyc <= m_k[d] + w;
        in_resp  = m_act[d] && cyc == m_k[d] + w + 1;
        check($sformatf("d%0d.busy", d), 32'(busy_o[d]), 32'(in_issue || in_resp));
        check($sformatf("d%0d.rom_cs", d), 32'(rom_cs_o[d]), 32'(in_issue));
        check($sformatf("d%0d.rom_read_en", d), 32'(rom_re_o[d]), 32'(in_issue));
        check($sformatf("d%0d.rom_addr", d), 32'(rom_addr_o[d]), in_issue ? 32'(m_a[d]) : 32'd0);
        check($sformatf("d%0d.ack0", d), 32'(ack0_o[d]), 32'(in_resp && !m_g[d]));
        check($sformatf("d%0d.ack1", d), 32'(ack1_o[d]), 32'(in_resp && m_g[d]));
        check($sformatf("d%0d.data_out", d), 32'(data_o[d]), 32'(m_data[d]));
    endtask

    task automatic log_acks();
        ack_t a;
        a.cyc = cyc;
        if (ack0_o[0]) begin a.r = 0; a.data = data_o[0]; alog0.push_back(a); end
        if (ack1_o[0]) begin a.r = 1; a.data = data_o[0]; alog0.push_back(a); end
        if (ack0_o[1]) begin a.r = 0; a.data = data_o[1]; alog1.push_back(a); end
        if (ack1_o[1]) begin a.r = 1; a.data = data_o[1]; alog1.push_back(a); end
    endtask

    // One clock: model at the edge, compare 1 time unit later, requesters react to acks
    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        compare_cycle(0);
        compare_cycle(1);
        log_acks();
        if (!hold) begin
            for (int d = 0; d < 2; d++) begin
                if (ack0_o[d]) req0_i[d] = 1'b0;
                if (ack1_o[d]) req1_i[d] = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic idle_all();
        for (int d = 0; d < 2; d++) begin
            req0_i[d]  = 1'b0;
            req1_i[d]  = 1'b0;
            addr0_i[d] = 3'd0;
            addr1_i[d] = 3'd0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        alog0.delete();
        alog1.delete();
    endtask

    function automatic ack_t get_ack(int d, int i);
        ack_t a;
        a.cyc  = -1;
        a.r    = -1;
        a.data = 8'h00;
        if (d == 0) begin
            if (i < alog0.size()) a = alog0[i];
        end else begin
            if (i < alog1.size()) a = alog1[i];
        end
        return a;
    endfunction

    function automatic int log_size(int d);
        return (d == 0) ? alog0.size() : alog1.size();
    endfunction

    task automatic rand_drive();
        rst = ($urandom_range(0, 199) == 0);
        for (int d = 0; d < 2; d++) begin
            if (!req0_i[d]) begin
                if ($urandom_range(0, 9) < 4) begin
                    req0_i[d]  = 1'b1;
                    addr0_i[d] = 3'($urandom_range(0, 7));
                end
            end else if ($urandom_range(0, 19) == 0) begin
                req0_i[d] = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                addr0_i[d] = 3'($urandom_range(0, 7));
            end
            if (!req1_i[d]) begin
                if ($urandom_range(0, 9) < 4) begin
                    req1_i[d]  = 1'b1;
                    addr1_i[d] = 3'($urandom_range(0, 7));
                end
            end else if ($urandom_range(0, 19) == 0) begin
                req1_i[d] = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                addr1_i[d] = 3'($urandom_range(0, 7));
            end
        end
    endtask

    initial begin
        int   cs_cnt;
        ack_t a;
        ack_t b;

        rst = 1'b1;
        idle_all();
        for (int d = 0; d < 2; d++) begin
            m_k[d] = 0; m_free[d] = 0; m_act[d] = 1'b0; m_g[d] = 1'b0;
            m_lg[d] = 1'b1; m_a[d] = 3'd0; m_data[d] = 8'h00;
        end
        step();
        step();
        check("rst.busy0", 32'(busy_o[0]), 32'd0);
        check("rst.cs1", 32'(rom_cs_o[1]), 32'd0);
        check("rst.data1", 32'(data_o[1]), 32'h00);
        rst = 1'b0;
        step();

        // Single request, WAIT_CYCLES=0, addr 5
        req0_i[0]  = 1'b1;
        addr0_i[0] = 3'd5;
        step();
        check("single.cs", 32'(rom_cs_o[0]), 32'd1);
        check("single.addr", 32'(rom_addr_o[0]), 32'd5);
        check("single.busy_a", 32'(busy_o[0]), 32'd1);
        step();
        check("single.ack0", 32'(ack0_o[0]), 32'd1);
        check("single.data", 32'(data_o[0]), 32'hFF);
        check("single.busy_b", 32'(busy_o[0]), 32'd1);
        check("single.cs_off", 32'(rom_cs_o[0]), 32'd0);
        step();
        check("single.ack_once", 32'(ack0_o[0]), 32'd0);
        check("single.busy_c", 32'(busy_o[0]), 32'd0);
        check("single.data_hold", 32'(data_o[0]), 32'hFF);

        // Wait states, WAIT_CYCLES=3, requester 1 addr 3
        clear_logs();
        req1_i[1]  = 1'b1;
        addr1_i[1] = 3'd3;
        cs_cnt     = 0;
        repeat (8) begin
            step();
            if (rom_cs_o[1]) cs_cnt++;
        end
        a = get_ack(1, 0);
        check("wait.cs_cycles", 32'(cs_cnt), 32'd4);
        check("wait.nacks", 32'(log_size(1)), 32'd1);
        check("wait.ack_r", 32'(a.r), 32'd1);
        check("wait.data", 32'(a.data), 32'h99);

        // Tie right after reset: requester 0 first, then requester 1
        do_reset();
        clear_logs();
        for (int d = 0; d < 2; d++) begin
            req0_i[d] = 1'b1; addr0_i[d] = 3'd1;
            req1_i[d] = 1'b1; addr1_i[d] = 3'd6;
        end
        repeat (16) step();
        for (int d = 0; d < 2; d++) begin
            a = get_ack(d, 0);
            b = get_ack(d, 1);
            check($sformatf("tie.d%0d.n", d), 32'(log_size(d)), 32'd2);
            check($sformatf("tie.d%0d.first_r", d), 32'(a.r), 32'd0);
            check($sformatf("tie.d%0d.first_data", d), 32'(a.data), 32'hAB);
            check($sformatf("tie.d%0d.second_r", d), 32'(b.r), 32'd1);
            check($sformatf("tie.d%0d.second_data", d), 32'(b.data), 32'hCD);
            check($sformatf("tie.d%0d.spacing", d), 32'(b.cyc - a.cyc), (d == 0) ? 32'd3 : 32'd6);
        end

        // Fairness: both requests held continuously
        do_reset();
        clear_logs();
        hold = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req0_i[d] = 1'b1; addr0_i[d] = 3'd2;
            req1_i[d] = 1'b1; addr1_i[d] = 3'd4;
        end
        repeat (45) step();
        hold = 1'b0;
        idle_all();
        repeat (8) step();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 6; i++) begin
                a = get_ack(d, i);
                check($sformatf("fair.d%0d.ack%0d", d, i), 32'(a.r), 32'(i % 2));
            end
        end

        // Reset during ISSUE aborts with no ack; next tie goes to requester 0
        clear_logs();
        req0_i[1]  = 1'b1;
        addr0_i[1] = 3'd2;
        step();
        step();
        check("abort.in_issue", 32'(rom_cs_o[1]), 32'd1);
        rst = 1'b1;
        req0_i[1] = 1'b0;
        step();
        rst = 1'b0;
        check("abort.ack0", 32'(ack0_o[1]), 32'd0);
        check("abort.ack1", 32'(ack1_o[1]), 32'd0);
        check("abort.busy", 32'(busy_o[1]), 32'd0);
        check("abort.cs", 32'(rom_cs_o[1]), 32'd0);
        check("abort.re", 32'(rom_re_o[1]), 32'd0);
        check("abort.addr", 32'(rom_addr_o[1]), 32'd0);
        check("abort.data", 32'(data_o[1]), 32'h00);
        step();
        check("abort.no_ack", 32'(log_size(1)), 32'd0);
        req0_i[1] = 1'b1; addr0_i[1] = 3'd0;
        req1_i[1] = 1'b1; addr1_i[1] = 3'd7;
        repeat (16) step();
        a = get_ack(1, 0);
        check("abort.tie_r", 32'(a.r), 32'd0);
        check("abort.tie_data", 32'(a.data), 32'h21);
        idle_all();
        repeat (4) step();

        // Address change after grant does not disturb the transaction
        clear_logs();
        for (int d = 0; d < 2; d++) begin
            req0_i[d] = 1'b1; addr0_i[d] = 3'd7;
        end
        step();
        for (int d = 0; d < 2; d++) addr0_i[d] = 3'd0;
        check("addrchg.d0.addr", 32'(rom_addr_o[0]), 32'd7);
        check("addrchg.d1.addr", 32'(rom_addr_o[1]), 32'd7);
        step();
        check("addrchg.d1.addr_late", 32'(rom_addr_o[1]), 32'd7);
        repeat (8) step();
        for (int d = 0; d < 2; d++) begin
            a = get_ack(d, 0);
            check($sformatf("addrchg.d%0d.data", d), 32'(a.data), 32'h88);
        end
        idle_all();
        repeat (4) step();

        // Randomized traffic with withdrawals, address churn and occasional reset
        repeat (RAND_STEPS) begin
            rand_drive();
            step();
        end
        rst = 1'b0;
        idle_all();
        repeat (8) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_arbiter_2x.md
ROM_ARBITER_2X -- requirements
Module: rom_arbiter_2x

Interface
REQ-001 The block SHALL have one parameter: WAIT_CYCLES, default 0, extra cycles rom_cs/rom_read_en are held before data capture (legal range 0-7).
REQ-002 The block SHALL have these ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, synchronous, active-high
- req0  input  1  requester 0 read request, level, held until ack0
- addr0  input  3  requester 0 ROM address
- req1  input  1  requester 1 read request, level, held until ack1
- addr1  input  3  requester 1 ROM address
- ack0  output  1  one-cycle pulse, data_out valid for requester 0
- ack1  output  1  one-cycle pulse, data_out valid for requester 1
- data_out  output  8  captured ROM word, held until next capture
- busy  output  1  high in any state other than IDLE
- rom_cs  output  1  ROM chip select
- rom_read_en  output  1  ROM read enable
- rom_addr  output  3  ROM address
- rom_data  input  8  ROM read data, combinational, high-Z when not selected

Function
REQ-003 The block SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-004 IDLE: on an edge with req0 or req1 high, the block SHALL select a winner, latch its address into an internal address register, record the winner ID, load the wait counter with WAIT_CYCLES, and go to ISSUE. With no request it SHALL stay in IDLE.
REQ-005 Arbitration SHALL be round-robin: with one request, that requester wins; with both, the requester not granted last wins; last_grant updates at each grant.
REQ-006 ISSUE: rom_cs=1, rom_read_en=1, rom_addr=latched address. While the counter is nonzero it SHALL decrement each edge and stay in ISSUE. On the edge where it is zero, rom_data SHALL be registered into data_out and the FSM SHALL go to RESP.
REQ-007 ISSUE SHALL last exactly WAIT_CYCLES+1 cycles.
REQ-008 RESP: the ack of the recorded winner SHALL be 1 for exactly this one cycle; the FSM SHALL go to IDLE on the next edge unconditionally.
REQ-009 Outside ISSUE, rom_cs=0, rom_read_en=0, rom_addr=3'b000.
REQ-010 Latency: a request sampled in IDLE at edge k SHALL produce ack high during the cycle after edge k+WAIT_CYCLES+1. data_out SHALL be stable from that edge until the next capture.
REQ-011 ack0 and ack1 SHALL never be high simultaneously, and SHALL be low outside RESP.
REQ-012 Request or address changes after the grant SHALL NOT affect the transaction in flight. A request withdrawn before its ack still completes, and its ack still pulses.
REQ-013 A requester that keeps req high after its ack SHALL be treated as a new request at the next IDLE edge, subject to round-robin.
REQ-014 Minimum spacing between back-to-back transactions SHALL be one IDLE cycle.
REQ-015 rom_data SHALL be sampled only at the ISSUE capture edge. X or Z at other times SHALL NOT propagate into data_out.

Reset
REQ-016 When rst is high at an edge, the block SHALL set: state IDLE, ack0=0, ack1=0, busy=0, data_out=8'h00, rom_cs=0, rom_read_en=0, rom_addr=0, wait counter=0, latched address=0, last_grant=1 (requester 0 wins the first tie).
REQ-017 Reset SHALL take priority over all other inputs, and reset asserted mid-transaction SHALL abort it with no ack issued.

Verification
REQ-018 The bench ROM model SHALL hold, at addresses 0-7: 21, AB, 33, 99, A3, FF, CD, 88 (hex).
REQ-019 Scenario, single request: WAIT_CYCLES=0, req0=1, addr0=5 -> one ISSUE cycle with rom_addr=5, then ack0 pulses once with data_out=8'hFF, busy high for 2 cycles.
REQ-020 Scenario, tie after reset: req0 (addr 1) and req1 (addr 6) rise together -> ack0 with 8'hAB first, then ack1 with 8'hCD; the two acks are separated by IDLE+ISSUE+RESP spacing.
REQ-021 Scenario, fairness: both requests held high continuously for 6 transactions -> acks strictly alternate 0,1,0,1,0,1.
REQ-022 Scenario, wait states: WAIT_CYCLES=3, req1=1, addr1=3 -> rom_cs high for exactly 4 cycles, then ack1 with data_out=8'h99.
REQ-023 Scenario, reset mid-operation: rst pulsed during ISSUE -> next cycle all outputs at reset values, no ack, and the next tie is granted to requester 0.
REQ-024 Scenario, address change after grant: addr0 changed from 7 to 0 during ISSUE -> rom_addr stays 7, and data_out=8'h88.
